cpc_pi_mailbox: RTL and testbench



---
 rtl/cpc_pi_mailbox.sv | 208 ++++++++++++++++++++
 tb/tb_cpc_pi_mailbox.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpc_pi_mailbox.sv
// rtl/cpc_pi_mailbox.sv - Z80 I/O-port mailbox bridging the CPC bus to Raspberry Pi GPIO
//
// Purpose: CPC OUT to the data port pushes bytes into a TX FIFO that is handed
// to the Pi with a 4-phase RDY/ACK handshake. Bytes strobed in by the Pi land
// in a single-entry RX register read back with IN. The status port reports
// {3'b0, tx_overflow, rx_overrun, tx_empty, tx_full, rx_valid}.
//
// Ports:
//   i_clk          CPC bus clock, all state on the rising edge
//   i_rst_n        asynchronous active-low reset
//   i_a            Z80 address bus
//   i_d_in         Z80 data bus, write side
//   o_d_out        read data to the Z80 data bus
//   o_d_oe         data bus drive enable
//   i_ioreq_b, i_rd_b, i_wr_b, i_m1_b   Z80 bus control, active-low
//   o_pi_data_out  TX byte presented to the Pi
//   o_pi_rdy       TX byte valid
//   i_pi_ack       Pi acknowledge (asynchronous)
//   i_pi_data_in   RX byte from the Pi (qualified by i_pi_stb)
//   i_pi_stb       Pi strobe (asynchronous)
//   o_pi_busy      RX register occupied
module cpc_pi_mailbox #(
   parameter logic [15:0] PORT_BASE  = 16'hFD80,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [15:0] i_a,
   input  logic [7:0]  i_d_in,
   output logic [7:0]  o_d_out,
   output logic        o_d_oe,
   input  logic        i_ioreq_b,
   input  logic        i_rd_b,
   input  logic        i_wr_b,
   input  logic        i_m1_b,
   output logic [7:0]  o_pi_data_out,
   output logic        o_pi_rdy,
   input  logic        i_pi_ack,
   input  logic [7:0]  i_pi_data_in,
   input  logic        i_pi_stb,
   output logic        o_pi_busy
);

   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam logic [15:0] STAT_PORT = PORT_BASE + 16'd1;

   typedef enum logic [1:0] {TX_IDLE, TX_PRESENT, TX_WAIT_LO} tx_state_t;

   // Bus decode: interrupt acknowledge (M1 low with IOREQ low) is never an I/O cycle.
   logic w_io_cyc, w_wr_data, w_rd_data, w_rd_stat;
   assign w_io_cyc  = !i_ioreq_b && i_m1_b;
   assign w_wr_data = w_io_cyc && !i_wr_b && (i_a == PORT_BASE);
   assign w_rd_data = w_io_cyc && !i_rd_b && (i_a == PORT_BASE);
   assign w_rd_stat = w_io_cyc && !i_rd_b && (i_a == STAT_PORT);

   // Previous samples of the decode give one event per bus cycle.
   logic r_wr_data_q, r_rd_data_q, r_rd_stat_q;
   logic w_wr_commit, w_rd_data_trail, w_rd_stat_trail;
   assign w_wr_commit     = w_wr_data && !r_wr_data_q;
   assign w_rd_data_trail = !w_rd_data && r_rd_data_q;
   assign w_rd_stat_trail = !w_rd_stat && r_rd_stat_q;

   // Synchronisers for the Pi-side asynchronous controls.
   logic r_ack_s1, r_ack_s, r_stb_s1, r_stb_s, r_stb_d;
   logic w_stb_rise;
   assign w_stb_rise = r_stb_s && !r_stb_d;

   // TX FIFO: the extra pointer MSB separates full from empty.
   logic [7:0]  r_mem [FIFO_DEPTH];
   logic [AW:0] r_wr_ptr, r_rd_ptr;
   logic        w_empty, w_full, w_push;
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   tx_state_t  r_tx_state, w_tx_next;
   logic       w_tx_load, w_tx_pop;
   logic [7:0] r_pi_data;

   // A push into a full FIFO is still accepted when the head leaves on the same edge.
   assign w_push = w_wr_commit && (!w_full || w_tx_pop);

   logic       r_rx_valid, r_rx_overrun, r_tx_overflow;
   logic [7:0] r_rx_data;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_data_q <= 1'b0;
         r_rd_data_q <= 1'b0;
         r_rd_stat_q <= 1'b0;
         r_ack_s1    <= 1'b0;
         r_ack_s     <= 1'b0;
         r_stb_s1    <= 1'b0;
         r_stb_s     <= 1'b0;
         r_stb_d     <= 1'b0;
      end else begin
         r_wr_data_q <= w_wr_data;
         r_rd_data_q <= w_rd_data;
         r_rd_stat_q <= w_rd_stat;
         r_ack_s1    <= i_pi_ack;
         r_ack_s     <= r_ack_s1;
         r_stb_s1    <= i_pi_stb;
         r_stb_s     <= r_stb_s1;
         r_stb_d     <= r_stb_s;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_d_in;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_tx_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_tx_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_wr_commit && !w_push) begin
            r_tx_overflow <= 1'b1;
         end else if (w_rd_stat_trail) begin
            r_tx_overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tx_state <= TX_IDLE;
         r_pi_data  <= 8'h00;
      end else begin
         r_tx_state <= w_tx_next;
         if (w_tx_load) begin
            r_pi_data <= r_mem[r_rd_ptr[AW-1:0]];
         end
      end
   end

   always_comb begin
      w_tx_next = r_tx_state;
      w_tx_load = 1'b0;
      w_tx_pop  = 1'b0;
      case (r_tx_state)
         TX_IDLE: begin
            if (!w_empty && !r_ack_s) begin
               w_tx_load = 1'b1;
               w_tx_next = TX_PRESENT;
            end
         end
         TX_PRESENT: begin
            if (r_ack_s) begin
               w_tx_pop  = 1'b1;
               w_tx_next = TX_WAIT_LO;
            end
         end
         TX_WAIT_LO: begin
            if (!r_ack_s) begin
               w_tx_next = TX_IDLE;
            end
         end
         default: w_tx_next = TX_IDLE;
      endcase
   end

   // A strobe landing on the data-read trailing edge refills the register
   // instead of counting as an overrun.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rx_data    <= 8'h00;
         r_rx_valid   <= 1'b0;
         r_rx_overrun <= 1'b0;
      end else begin
         if (w_stb_rise && (!r_rx_valid || w_rd_data_trail)) begin
            r_rx_data  <= i_pi_data_in;
            r_rx_valid <= 1'b1;
         end else if (w_rd_data_trail) begin
            r_rx_valid <= 1'b0;
         end
         if (w_stb_rise && r_rx_valid && !w_rd_data_trail) begin
            r_rx_overrun <= 1'b1;
         end else if (w_rd_stat_trail) begin
            r_rx_overrun <= 1'b0;
         end
      end
   end

   always_comb begin
      o_d_out = 8'h00;
      if (i_rst_n && w_rd_data) begin
         o_d_out = r_rx_data;
      end else if (i_rst_n && w_rd_stat) begin
         o_d_out = {3'b000, r_tx_overflow, r_rx_overrun, w_empty, w_full, r_rx_valid};
      end
   end

   assign o_d_oe        = i_rst_n && (w_rd_data || w_rd_stat);
   assign o_pi_rdy      = (r_tx_state == TX_PRESENT);
   assign o_pi_data_out = r_pi_data;
   assign o_pi_busy     = r_rx_valid;

endmodule

// File: tb/tb_cpc_pi_mailbox.sv
// tb/tb_cpc_pi_mailbox.sv - self-checking bench for cpc_pi_mailbox
module tb_cpc_pi_mailbox;

   localparam logic [15:0] DATA_PORT = 16'hFD80;
   localparam logic [15:0] STAT_PORT = 16'hFD81;
   localparam int          DEPTH     = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] a = 16'h0000;
   logic [7:0]  d_in = 8'h00;
   logic [7:0]  d_out;
   logic        d_oe;
   logic        ioreq_b = 1'b1, rd_b = 1'b1, wr_b = 1'b1, m1_b = 1'b1;
   logic [7:0]  pi_data_out;
   logic        pi_rdy;
   logic        pi_ack = 1'b0;
   logic [7:0]  pi_data_in = 8'h00;
   logic        pi_stb = 1'b0;
   logic        pi_busy;

   always #5 clk = ~clk;

   cpc_pi_mailbox #(.PORT_BASE(DATA_PORT), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_d_in(d_in),
      .o_d_out(d_out), .o_d_oe(d_oe),
      .i_ioreq_b(ioreq_b), .i_rd_b(rd_b), .i_wr_b(wr_b), .i_m1_b(m1_b),
      .o_pi_data_out(pi_data_out), .o_pi_rdy(pi_rdy), .i_pi_ack(pi_ack),
      .i_pi_data_in(pi_data_in), .i_pi_stb(pi_stb), .o_pi_busy(pi_busy)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: mailbox contents described as counts, flags and queues.
   int         m_cnt = 0;
   logic       m_ovf = 1'b0, m_ovr = 1'b0, m_rxv = 1'b0;
   logic [7:0] m_rxd = 8'h00;
   logic [7:0] exp_pi_q[$];
   logic [7:0] rd_q[$];

   function automatic logic [7:0] m_status();
      return {3'b000, m_ovf, m_ovr, (m_cnt == 0), (m_cnt == DEPTH), m_rxv};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares whatever the DUT presents against the scoreboard queues.
   logic       pi_rdy_prev = 1'b0, d_oe_prev = 1'b0;
   logic [7:0] pi_hold = 8'h00;
   always @(negedge clk) begin
      if (rst_n) begin
         if (pi_rdy && !pi_rdy_prev) begin
            if (exp_pi_q.size() == 0) chk("pi_unexpected_rdy", 1, 0);
            else chk("pi_data", {24'h0, pi_data_out}, {24'h0, exp_pi_q.pop_front()});
            pi_hold = pi_data_out;
         end else if (pi_rdy && pi_rdy_prev) begin
            chk("pi_data_stable", {24'h0, pi_data_out}, {24'h0, pi_hold});
         end
         if (d_oe && !d_oe_prev) begin
            if (rd_q.size() == 0) chk("rd_unexpected_oe", 1, 0);
            else chk("rd_data", {24'h0, d_out}, {24'h0, rd_q.pop_front()});
         end
      end
      pi_rdy_prev = pi_rdy;
      d_oe_prev   = d_oe;
   end

   task automatic io_write(input logic [15:0] addr, input logic [7:0] data);
      @(posedge clk); #1;
      a = addr; d_in = data; ioreq_b = 1'b0; wr_b = 1'b0;
      repeat (3) @(posedge clk);
      #1; ioreq_b = 1'b1; wr_b = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic io_read(input logic [15:0] addr, input logic [7:0] exp);
      rd_q.push_back(exp);
      @(posedge clk); #1;
      a = addr; ioreq_b = 1'b0; rd_b = 1'b0;
      repeat (3) @(posedge clk);
      #1; ioreq_b = 1'b1; rd_b = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic z_out(input logic [7:0] data);
      if (m_cnt < DEPTH) begin
         m_cnt++;
         exp_pi_q.push_back(data);
      end else begin
         m_ovf = 1'b1;
      end
      io_write(DATA_PORT, data);
   endtask

   task automatic z_in_stat();
      io_read(STAT_PORT, m_status());
      m_ovf = 1'b0;
      m_ovr = 1'b0;
   endtask

   task automatic z_in_data();
      io_read(DATA_PORT, m_rxd);
      m_rxv = 1'b0;
   endtask

   task automatic pi_strobe(input logic [7:0] b);
      @(posedge clk); #1;
      pi_data_in = b; pi_stb = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("busy_after_stb", {31'h0, pi_busy}, 1);
      if (!m_rxv) begin
         m_rxd = b;
         m_rxv = 1'b1;
      end else begin
         m_ovr = 1'b1;
      end
      @(posedge clk); #1;
      pi_stb = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic pi_take();
      int k;
      bit seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         seen = pi_rdy;
      end
      if (!seen) begin
         chk("pi_rdy_timeout", 0, 1);
      end else begin
         @(posedge clk); #1;
         pi_ack = 1'b1;
         for (k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (!pi_rdy) break;
         end
         chk("ack_to_rdy_low", k, 3);
         m_cnt--;
         pi_ack = 1'b0;
         repeat (4) @(posedge clk);
      end
   endtask

   // Strobe timed so its synchronised rise lands on the data-read trailing edge.
   task automatic sim_capture(input logic [7:0] b);
      rd_q.push_back(m_rxd);
      @(posedge clk); #1;
      a = DATA_PORT; ioreq_b = 1'b0; rd_b = 1'b0;
      pi_data_in = b; pi_stb = 1'b1;
      repeat (2) @(posedge clk);
      #1; ioreq_b = 1'b1; rd_b = 1'b1;
      @(posedge clk);
      m_rxd = b;
      m_rxv = 1'b1;
      @(negedge clk);
      chk("sim_busy", {31'h0, pi_busy}, 1);
      @(posedge clk); #1;
      pi_stb = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      // Reset held while a status read is on the bus.
      a = STAT_PORT; ioreq_b = 1'b0; rd_b = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_d_oe", {31'h0, d_oe}, 0);
      chk("rst_d_out", {24'h0, d_out}, 0);
      chk("rst_pi_rdy", {31'h0, pi_rdy}, 0);
      chk("rst_pi_busy", {31'h0, pi_busy}, 0);
      ioreq_b = 1'b1; rd_b = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      chk("rst_status_model", {24'h0, m_status()}, 32'h04);
      z_in_stat();

      // Single byte: PI_RDY one clock after the commit edge.
      m_cnt++;
      exp_pi_q.push_back(8'h5A);
      @(posedge clk); #1;
      a = DATA_PORT; d_in = 8'h5A; ioreq_b = 1'b0; wr_b = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rdy_at_commit", {31'h0, pi_rdy}, 0);
      @(posedge clk);
      @(negedge clk);
      chk("rdy_commit_plus1", {31'h0, pi_rdy}, 1);
      chk("data_commit_plus1", {24'h0, pi_data_out}, 32'h5A);
      @(posedge clk); #1;
      ioreq_b = 1'b1; wr_b = 1'b1;
      repeat (2) @(posedge clk);
      pi_take();
      z_in_stat();

      // Overflow: five pushes into four slots with the Pi idle.
      for (int i = 1; i <= 5; i++) z_out(8'(i));
      z_in_stat();
      z_in_stat();
      repeat (4) pi_take();

      // Three full passes around the buffer.
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < DEPTH; i++) z_out(8'($urandom));
         z_in_stat();
         repeat (DEPTH) pi_take();
      end

      // RX path: capture, overrun, read-back.
      pi_strobe(8'hC3);
      z_in_stat();
      pi_strobe(8'h77);
      z_in_stat();
      z_in_data();
      @(negedge clk);
      chk("busy_after_read", {31'h0, pi_busy}, 0);

      // Strobe coinciding with the data-read trailing edge.
      pi_strobe(8'h11);
      sim_capture(8'h22);
      z_in_stat();
      z_in_data();

      // Interrupt acknowledge at the data port is never decoded.
      @(posedge clk); #1;
      a = DATA_PORT; d_in = 8'hAA; m1_b = 1'b0; ioreq_b = 1'b0; wr_b = 1'b0; rd_b = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("m1_no_oe", {31'h0, d_oe}, 0);
      ioreq_b = 1'b1; wr_b = 1'b1; rd_b = 1'b1; m1_b = 1'b1;
      repeat (3) @(posedge clk);
      z_in_stat();

      // Randomised mix of bus and Pi activity.
      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 4))
            0: repeat ($urandom_range(1, 3)) z_out(8'($urandom));
            1: z_in_stat();
            2: z_in_data();
            3: pi_strobe(8'($urandom));
            default: if (m_cnt > 0) pi_take();
         endcase
      end
      while (m_cnt > 0) pi_take();
      z_in_stat();

      // Reset mid-handshake drops PI_RDY and PI_BUSY without a clock.
      z_out(8'h3C);
      z_out(8'h4D);
      pi_strobe(8'h99);
      @(negedge clk);
      chk("pre_reset_rdy", {31'h0, pi_rdy}, 1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_rdy", {31'h0, pi_rdy}, 0);
      chk("async_rst_busy", {31'h0, pi_busy}, 0);
      m_cnt = 0; m_ovf = 1'b0; m_ovr = 1'b0; m_rxv = 1'b0; m_rxd = 8'h00;
      exp_pi_q.delete();
      rd_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      z_in_stat();
      z_in_data();
      repeat (20) @(posedge clk);

      chk("pi_queue_drained", exp_pi_q.size(), 0);
      chk("rd_queue_drained", rd_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
